// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between the CPU fetch and data ports.
// Each CPU step runs as one transaction: the data access first, then the fetch, then one DONE cycle.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_rd_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_data_o,
  output logic        instr_ready_o,
  input  logic        data_rd_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_be_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o
);

  localparam int unsigned CW   = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  localparam int unsigned TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {IDLE, DATA, INSTR, DONE} state_t;

  state_t        state_q;
  logic          cap_instr_rd_q;
  logic [31:0]   cap_instr_addr_q;
  logic          cap_data_wr_q;
  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   instr_buf_q;
  logic [31:0]   data_buf_q;
  logic [31:0]   instr_hold_q;
  logic [31:0]   data_hold_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic          live_q;

  logic any_req;
  logic timeout_hit;
  logic xfer_end;

  assign any_req     = instr_rd_i | data_rd_i | data_wr_i;
  // The abort fires on the edge where the counter would reach TIMEOUT; an ack in that cycle wins.
  assign timeout_hit = (TIMEOUT != 0) && !mem_ack_i && (cnt_q == CW'(TLIM));
  assign xfer_end    = mem_ack_i | timeout_hit;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q          <= IDLE;
      cap_instr_rd_q   <= 1'b0;
      cap_instr_addr_q <= '0;
      cap_data_wr_q    <= 1'b0;
      req_q            <= 1'b0;
      we_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      be_q             <= '0;
      instr_buf_q      <= '0;
      data_buf_q       <= '0;
      instr_hold_q     <= '0;
      data_hold_q      <= '0;
      err_q            <= 1'b0;
      cnt_q            <= '0;
      live_q           <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            cap_instr_rd_q   <= instr_rd_i;
            cap_instr_addr_q <= instr_addr_i;
            cap_data_wr_q    <= data_wr_i;
            cnt_q            <= '0;
            req_q            <= 1'b1;
            if (data_rd_i || data_wr_i) begin
              state_q <= DATA;
              we_q    <= data_wr_i;
              addr_q  <= data_addr_i;
              be_q    <= data_be_i;
              wdata_q <= data_wr_i ? data_wdata_i : 32'h0;
            end else begin
              state_q <= INSTR;
              we_q    <= 1'b0;
              addr_q  <= instr_addr_i;
              be_q    <= 4'hF;
              wdata_q <= 32'h0;
            end
          end
        end
        DATA: begin
          if (xfer_end) begin
            if (!cap_data_wr_q) data_buf_q <= mem_ack_i ? mem_rdata_i : ERR_DATA;
            if (timeout_hit) err_q <= 1'b1;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            // Fetch follows back-to-back: req stays high and only the address changes.
            if (cap_instr_rd_q) begin
              state_q <= INSTR;
              addr_q  <= cap_instr_addr_q;
              be_q    <= 4'hF;
            end else begin
              state_q <= DONE;
              req_q   <= 1'b0;
              addr_q  <= '0;
              be_q    <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        INSTR: begin
          if (xfer_end) begin
            instr_buf_q <= mem_ack_i ? mem_rdata_i : ERR_DATA;
            if (timeout_hit) err_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q      <= IDLE;
          instr_hold_q <= instr_buf_q;
          data_hold_q  <= data_buf_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_be_o      = be_q;
  assign err_o         = err_q;
  // Read data is only published in DONE so the CPU never sees a half-finished transaction.
  assign instr_data_o  = (state_q == DONE) ? instr_buf_q : instr_hold_q;
  assign data_rdata_o  = (state_q == DONE) ? data_buf_q : data_hold_q;
  assign instr_ready_o = live_q & ((state_q == DONE) | ((state_q == IDLE) & ~any_req));
  assign data_ready_o  = live_q & ((state_q == DONE) | ((state_q == IDLE) & ~any_req));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a bus responder with wait states/hang,
// and a scoreboard of expected bus transfers pushed as each CPU request is driven.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_rd_i;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_data_o;
  logic        instr_ready_o;
  logic        data_rd_i;
  logic        data_wr_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_rdata_o;
  logic        data_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        mem_ack_i = 1'b0;
  logic        err_o;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } busT;

  busT         busExp[$];
  busT         busGot[$];
  logic [31:0] memWords [logic [31:0]];
  int          waitStates = 0;
  bit          hang = 1'b0;
  int          waitCnt = 0;
  int          checks = 0;
  int          failures = 0;

  mem_port_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_rd_i(instr_rd_i), .instr_addr_i(instr_addr_i),
    .instr_data_o(instr_data_o), .instr_ready_o(instr_ready_o),
    .data_rd_i(data_rd_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_rdata_o(data_rdata_o), .data_ready_o(data_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memWords.exists(a) ? memWords[a] : 32'h0;
  endfunction

  // Memory responder: acks after waitStates idle req cycles, never while hung.
  always @(negedge clk_i) begin
    if (mem_req_o && rst_i && !hang) begin
      if (waitCnt == waitStates) begin
        busT t;
        t.addr = mem_addr_o;
        t.we = mem_we_o;
        t.be = mem_be_o;
        t.wdata = mem_wdata_o;
        busGot.push_back(t);
        mem_ack_i = 1'b1;
        mem_rdata_i = mem_we_o ? 32'h5A5A5A5A : memRead(mem_addr_o);
        waitCnt = 0;
      end else begin
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'h0;
        waitCnt++;
      end
    end else begin
      mem_ack_i = 1'b0;
      mem_rdata_i = 32'h0;
      waitCnt = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ird, input logic [31:0] iaddr, input logic drd,
                               input logic dwr, input logic [31:0] daddr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input bit expectBus);
    busT t;
    instr_rd_i = ird;
    instr_addr_i = iaddr;
    data_rd_i = drd;
    data_wr_i = dwr;
    data_addr_i = daddr;
    data_wdata_i = wdata;
    data_be_i = be;
    if (expectBus) begin
      if (drd || dwr) begin
        t.addr = daddr;
        t.we = dwr;
        t.be = be;
        t.wdata = dwr ? wdata : 32'h0;
        busExp.push_back(t);
      end
      if (ird) begin
        t.addr = iaddr;
        t.we = 1'b0;
        t.be = 4'hF;
        t.wdata = 32'h0;
        busExp.push_back(t);
      end
    end
  endtask

  task automatic driveIdle();
    instr_rd_i = 1'b0;
    instr_addr_i = 32'h0;
    data_rd_i = 1'b0;
    data_wr_i = 1'b0;
    data_addr_i = 32'h0;
    data_wdata_i = 32'h0;
    data_be_i = 4'h0;
  endtask

  task automatic waitReady(input string tag, input int expCycles);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(instr_ready_o && data_ready_o) && n < 40);
    checkOutput({tag, ".latency"}, 32'(n), 32'(expCycles));
  endtask

  task automatic finishTxn(input string tag);
    @(posedge clk_i);
    #1 driveIdle();
    @(negedge clk_i);
    checkOutput({tag, ".idleInstrReady"}, 32'(instr_ready_o), 32'd1);
    checkOutput({tag, ".idleDataReady"}, 32'(data_ready_o), 32'd1);
  endtask

  task automatic checkBus(input string tag);
    checkOutput({tag, ".busCount"}, 32'(busGot.size()), 32'(busExp.size()));
    while (busGot.size() > 0 && busExp.size() > 0) begin
      busT g;
      busT e;
      g = busGot.pop_front();
      e = busExp.pop_front();
      checkOutput({tag, ".busAddr"}, g.addr, e.addr);
      checkOutput({tag, ".busWe"}, 32'(g.we), 32'(e.we));
      checkOutput({tag, ".busBe"}, 32'(g.be), 32'(e.be));
      checkOutput({tag, ".busWdata"}, g.wdata, e.wdata);
    end
    busGot.delete();
    busExp.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL tb.globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] global time limit expired");
  end

  initial begin
    int n;
    rst_i = 1'b0;
    driveIdle();
    repeat (2) @(negedge clk_i);
    checkOutput("rst.req", 32'(mem_req_o), 32'd0);
    checkOutput("rst.instrReady", 32'(instr_ready_o), 32'd0);
    checkOutput("rst.dataReady", 32'(data_ready_o), 32'd0);
    checkOutput("rst.err", 32'(err_o), 32'd0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("rst.idleReady", 32'(instr_ready_o & data_ready_o), 32'd1);

    // Reset in the middle of a hung data access.
    hang = 1'b1;
    @(posedge clk_i);
    #1 applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!mem_req_o && n < 10);
    checkOutput("t1.reqSeen", 32'(mem_req_o), 32'd1);
    rst_i = 1'b0;
    #1;
    checkOutput("t1.reqDropped", 32'(mem_req_o), 32'd0);
    checkOutput("t1.readies", 32'(instr_ready_o | data_ready_o), 32'd0);
    checkOutput("t1.err", 32'(err_o), 32'd0);
    driveIdle();
    hang = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("t1.readyAfter", 32'(instr_ready_o & data_ready_o), 32'd1);
    checkOutput("t1.reqAfter", 32'(mem_req_o), 32'd0);
    checkBus("t1");

    // Fetch only, zero wait.
    memWords[32'h100] = 32'h00500093;
    waitStates = 0;
    @(posedge clk_i);
    #1 applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    waitReady("t2", 3);
    checkOutput("t2.instrData", instr_data_o, 32'h00500093);
    checkOutput("t2.dataRdata", data_rdata_o, 32'h0);
    checkOutput("t2.err", 32'(err_o), 32'd0);
    finishTxn("t2");
    checkOutput("t2.instrHold", instr_data_o, 32'h00500093);
    checkBus("t2");

    // Load + fetch, two wait states each.
    memWords[32'h2000] = 32'h11223344;
    memWords[32'h104] = 32'hFE010113;
    waitStates = 2;
    @(posedge clk_i);
    #1 applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1);
    waitReady("t3", 8);
    checkOutput("t3.dataRdata", data_rdata_o, 32'h11223344);
    checkOutput("t3.instrData", instr_data_o, 32'hFE010113);
    finishTxn("t3");
    checkBus("t3");

    // Store (read also raised, write wins) + fetch.
    memWords[32'h108] = 32'h00000013;
    waitStates = 0;
    @(posedge clk_i);
    #1 applyStimulus(1'b1, 32'h108, 1'b1, 1'b1, 32'h3002, 32'hCAFEBABE, 4'b0011, 1'b1);
    waitReady("t4", 4);
    checkOutput("t4.dataRdata", data_rdata_o, 32'h11223344);
    checkOutput("t4.instrData", instr_data_o, 32'h00000013);
    finishTxn("t4");
    checkBus("t4");

    // CPU changes the fetch address mid-transaction.
    memWords[32'h200] = 32'h00000193;
    waitStates = 2;
    @(posedge clk_i);
    #1 applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    repeat (2) @(negedge clk_i);
    instr_addr_i = 32'h200;
    waitReady("t5a", 3);
    checkOutput("t5a.instrData", instr_data_o, 32'h00500093);
    waitStates = 0;
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    waitReady("t5b", 3);
    checkOutput("t5b.instrData", instr_data_o, 32'h00000193);
    finishTxn("t5");
    checkBus("t5");

    // Hung fetch trips the watchdog after four req cycles.
    hang = 1'b1;
    @(posedge clk_i);
    #1 applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    waitReady("t6", 6);
    checkOutput("t6.instrData", instr_data_o, 32'hDEADBEEF);
    checkOutput("t6.err", 32'(err_o), 32'd1);
    checkOutput("t6.dataRdata", data_rdata_o, 32'h11223344);
    finishTxn("t6");
    hang = 1'b0;
    memWords[32'h2004] = 32'h55667788;
    memWords[32'h10C] = 32'h00100073;
    waitStates = 1;
    @(posedge clk_i);
    #1 applyStimulus(1'b1, 32'h10C, 1'b1, 1'b0, 32'h2004, 32'h0, 4'b1100, 1'b1);
    waitReady("t6b", 6);
    checkOutput("t6b.dataRdata", data_rdata_o, 32'h55667788);
    checkOutput("t6b.instrData", instr_data_o, 32'h00100073);
    checkOutput("t6b.errSticky", 32'(err_o), 32'd1);
    finishTxn("t6b");
    checkBus("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
